picosoc_mem_ctrl: RTL

Bus-side controller for the on-chip `picosoc_mem` SRAM. It accepts PicoRV32 native memory-bus transactions and decodes them against a configurable base address. It drives the SRAM's `wen`/`addr`/`wdata` port, samples its one-cycle-latency `rdata`, and returns `mem_ready`/`mem_rdata` to the core. After reset it optionally zero-fills the whole array and stalls the bus until the fill is finished.

---
 rtl/picosoc_mem_ctrl_if.sv | 20 ++
 rtl/picosoc_mem_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/picosoc_mem_ctrl_if.sv
// PicoRV32 native memory bus between the core and the SRAM controller.
interface picosoc_mem_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        oob;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, oob
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, oob
  );
endinterface

// File: rtl/picosoc_mem_ctrl.sv
// Bus-side controller for the picosoc_mem SRAM: address decode, one-cycle
// read latency handling and an optional zero-fill after reset.
module picosoc_mem_ctrl #(
  parameter int unsigned WORDS          = 256,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      resetn,
  picosoc_mem_ctrl_if.slave         bus,
  output logic                      init_done,
  output logic [3:0]                ram_wen,
  output logic [21:0]               ram_addr,
  output logic [31:0]               ram_wdata,
  input  logic [31:0]               ram_rdata
);

  localparam int unsigned CNT_W     = $clog2(WORDS + 1);
  localparam logic [31:0] RANGE     = 32'(WORDS * 4);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS);

  typedef enum logic [1:0] {
    ST_CLEAR  = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RDATA  = 2'd3
  } state_e;

  localparam state_e RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_read_q, is_read_d;
  logic             oob_flag_q, oob_flag_d;
  logic             mem_ready_q, mem_ready_d;
  logic             oob_q, oob_d;
  logic [31:0]      mem_rdata_q, mem_rdata_d;
  logic [3:0]       ram_wen_q, ram_wen_d;
  logic [21:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wdata_q, ram_wdata_d;
  logic             init_done_q, init_done_d;

  logic        accept;
  logic [31:0] offset;
  logic        in_range;
  logic        clear_end;

  // Modulo subtraction makes addresses below the base wrap out of range.
  assign offset    = bus.mem_addr - BASE_ADDR;
  assign in_range  = offset < RANGE;
  assign accept    = bus.mem_valid && !mem_ready_q;
  assign clear_end = cnt_q == LAST;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= RST_STATE;
      cnt_q       <= '0;
      is_read_q   <= 1'b0;
      oob_flag_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      oob_q       <= 1'b0;
      mem_rdata_q <= '0;
      ram_wen_q   <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_read_q   <= is_read_d;
      oob_flag_q  <= oob_flag_d;
      mem_ready_q <= mem_ready_d;
      oob_q       <= oob_d;
      mem_rdata_q <= mem_rdata_d;
      ram_wen_q   <= ram_wen_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      init_done_q <= init_done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_CLEAR:  if (clear_end) state_d = ST_IDLE;
      ST_IDLE:   if (accept) state_d = ST_ACCESS;
      ST_ACCESS: state_d = is_read_q ? ST_RDATA : ST_IDLE;
      ST_RDATA:  state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and transaction context.
  always_comb begin
    cnt_d       = cnt_q;
    is_read_d   = is_read_q;
    oob_flag_d  = oob_flag_q;
    mem_ready_d = 1'b0;
    oob_d       = 1'b0;
    mem_rdata_d = mem_rdata_q;
    ram_wen_d   = ram_wen_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_CLEAR: begin
        if (clear_end) begin
          ram_wen_d   = 4'h0;
          init_done_d = 1'b1;
        end else begin
          ram_wen_d   = 4'hF;
          ram_addr_d  = 22'(cnt_q);
          ram_wdata_d = 32'h0;
          cnt_d       = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        init_done_d = 1'b1;
        if (accept) begin
          ram_addr_d  = offset[23:2];
          ram_wdata_d = bus.mem_wdata;
          ram_wen_d   = in_range ? bus.mem_wstrb : 4'h0;
          is_read_d   = bus.mem_wstrb == 4'h0;
          oob_flag_d  = !in_range;
        end
      end
      ST_ACCESS: begin
        ram_wen_d = 4'h0;
        if (!is_read_q) begin
          mem_ready_d = 1'b1;
          oob_d       = oob_flag_q;
        end
      end
      ST_RDATA: begin
        mem_rdata_d = oob_flag_q ? 32'h0 : ram_rdata;
        mem_ready_d = 1'b1;
        oob_d       = oob_flag_q;
      end
      default: ;
    endcase
  end

  assign bus.mem_ready = mem_ready_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.oob       = oob_q;
  assign init_done     = init_done_q;
  assign ram_wen       = ram_wen_q;
  assign ram_addr      = ram_addr_q;
  assign ram_wdata     = ram_wdata_q;

endmodule
